datapath_ctrl: RTL and testbench

Moore FSM that sequences the 16-bit register-file/ALU datapath to execute one Simple-RISC instruction per start/done handshake. It latches the instruction, decodes opcode, op and register fields, and drives every datapath control input (register read/write, A/B/C/status enables, shift, ALU op, muxes) across the required cycles. It sits between the instruction source (a test harness now, fetch logic later) and the datapath.

---
 rtl/datapath_ctrl.sv | 179 +++++++++++++++++
 tb/tb_datapath_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_ctrl.sv
// Moore controller that steps the 16-bit register-file/ALU datapath through one
// Simple-RISC instruction per start/done handshake; every control output is registered.
module datapath_ctrl #(
    parameter bit IMM_SEXT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] instr_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] datapath_in,
    output logic        wb_sel,
    output logic [2:0]  w_addr,
    output logic        w_en,
    output logic [2:0]  r_addr,
    output logic        en_A,
    output logic        en_B,
    output logic [1:0]  shift_op,
    output logic        sel_A,
    output logic        sel_B,
    output logic [1:0]  ALU_op,
    output logic        en_C,
    output logic        en_status
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_LDA, S_LDB, S_EXEC, S_WB, S_WIMM, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        K_ILL, K_MOVI, K_MOV, K_ADD, K_CMP, K_AND, K_MVN
    } kind_t;

    state_t      state;
    logic [15:0] ir;
    kind_t       kind;

    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;
    logic [15:0] imm_ext;

    assign rn      = ir[10:8];
    assign rd      = ir[7:5];
    assign sh      = ir[4:3];
    assign rm      = ir[2:0];
    assign imm_ext = {{8{ir[7] & IMM_SEXT}}, ir[7:0]};

    always_comb begin
        kind = K_ILL;
        case (ir[15:11])
            5'b110_10: kind = K_MOVI;
            5'b110_00: kind = K_MOV;
            5'b101_00: kind = K_ADD;
            5'b101_01: kind = K_CMP;
            5'b101_10: kind = K_AND;
            5'b101_11: kind = K_MVN;
            default:   kind = K_ILL;
        endcase
    end

    // Each branch loads the outputs belonging to the state being entered, so the
    // registered outputs line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ir          <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            datapath_in <= '0;
            wb_sel      <= 1'b0;
            w_addr      <= '0;
            w_en        <= 1'b0;
            r_addr      <= '0;
            en_A        <= 1'b0;
            en_B        <= 1'b0;
            shift_op    <= '0;
            sel_A       <= 1'b0;
            sel_B       <= 1'b0;
            ALU_op      <= '0;
            en_C        <= 1'b0;
            en_status   <= 1'b0;
        end else begin
            // NOTE: every output gets a default here so no enable can linger past
            // its state; all state uses non-blocking assignment to avoid ordering races.
            busy        <= 1'b1;
            done        <= 1'b0;
            datapath_in <= '0;
            wb_sel      <= 1'b0;
            w_addr      <= '0;
            w_en        <= 1'b0;
            r_addr      <= '0;
            en_A        <= 1'b0;
            en_B        <= 1'b0;
            shift_op    <= '0;
            sel_A       <= 1'b0;
            sel_B       <= 1'b0;
            ALU_op      <= '0;
            en_C        <= 1'b0;
            en_status   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        ir    <= instr_in;
                        err   <= 1'b0;
                        state <= S_DECODE;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                S_DECODE: begin
                    case (kind)
                        K_MOVI: begin
                            state       <= S_WIMM;
                            wb_sel      <= 1'b1;
                            w_addr      <= rn;
                            w_en        <= 1'b1;
                            datapath_in <= imm_ext;
                        end
                        K_ADD, K_AND, K_CMP: begin
                            state  <= S_LDA;
                            r_addr <= rn;
                            en_A   <= 1'b1;
                        end
                        K_MOV, K_MVN: begin
                            state  <= S_LDB;
                            r_addr <= rm;
                            en_B   <= 1'b1;
                        end
                        default: begin
                            state <= S_DONE;
                            err   <= 1'b1;
                            done  <= 1'b1;
                        end
                    endcase
                end
                S_LDA: begin
                    state  <= S_LDB;
                    r_addr <= rm;
                    en_B   <= 1'b1;
                end
                S_LDB: begin
                    state    <= S_EXEC;
                    shift_op <= sh;
                    case (kind)
                        K_MOV:   begin sel_A <= 1'b1; ALU_op <= 2'b00; en_C <= 1'b1; end
                        K_ADD:   begin ALU_op <= 2'b00; en_C <= 1'b1; end
                        K_AND:   begin ALU_op <= 2'b10; en_C <= 1'b1; end
                        K_MVN:   begin ALU_op <= 2'b11; en_C <= 1'b1; end
                        default: begin ALU_op <= 2'b01; en_status <= 1'b1; end
                    endcase
                end
                S_EXEC: begin
                    if (kind == K_CMP) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state  <= S_WB;
                        w_addr <= rd;
                        w_en   <= 1'b1;
                    end
                end
                S_WB, S_WIMM: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                default: begin
                    // DONE returns to IDLE regardless of start
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: per-instruction phase model checked every cycle, a small
// register-file/ALU model driven by the controller, and directed literal checks.
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] instr_in = '0;

    logic        busy, done, err, wb_sel, w_en, en_A, en_B, sel_A, sel_B, en_C, en_status;
    logic [15:0] datapath_in;
    logic [2:0]  w_addr, r_addr;
    logic [1:0]  shift_op, ALU_op;

    logic        z_busy, z_done, z_err, z_wb_sel, z_w_en, z_en_A, z_en_B, z_sel_A, z_sel_B;
    logic        z_en_C, z_en_status;
    logic [15:0] z_datapath_in;
    logic [2:0]  z_w_addr, z_r_addr;
    logic [1:0]  z_shift_op, z_ALU_op;

    always #5 clk = ~clk;

    datapath_ctrl #(.IMM_SEXT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr_in(instr_in),
        .busy(busy), .done(done), .err(err), .datapath_in(datapath_in),
        .wb_sel(wb_sel), .w_addr(w_addr), .w_en(w_en), .r_addr(r_addr),
        .en_A(en_A), .en_B(en_B), .shift_op(shift_op), .sel_A(sel_A),
        .sel_B(sel_B), .ALU_op(ALU_op), .en_C(en_C), .en_status(en_status)
    );

    datapath_ctrl #(.IMM_SEXT(1'b0)) dut_zext (
        .clk(clk), .rst_n(rst_n), .start(start), .instr_in(instr_in),
        .busy(z_busy), .done(z_done), .err(z_err), .datapath_in(z_datapath_in),
        .wb_sel(z_wb_sel), .w_addr(z_w_addr), .w_en(z_w_en), .r_addr(z_r_addr),
        .en_A(z_en_A), .en_B(z_en_B), .shift_op(z_shift_op), .sel_A(z_sel_A),
        .sel_B(z_sel_B), .ALU_op(z_ALU_op), .en_C(z_en_C), .en_status(z_en_status)
    );

    typedef struct packed {
        logic        busy, done, err;
        logic [15:0] dpin;
        logic [15:0] dpin_z;
        logic        wb_sel;
        logic [2:0]  w_addr;
        logic        w_en;
        logic [2:0]  r_addr;
        logic        en_A, en_B;
        logic [1:0]  shift_op;
        logic        sel_A, sel_B;
        logic [1:0]  alu;
        logic        en_C, en_status;
    } ovec_t;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act_v, exp_v);
        end
    endtask

    // Observed outputs; the zero-extending instance contributes only its immediate
    ovec_t act;
    always_comb begin
        act = '0;
        act.busy = busy;       act.done = done;         act.err = err;
        act.dpin = datapath_in; act.dpin_z = z_datapath_in;
        act.wb_sel = wb_sel;   act.w_addr = w_addr;     act.w_en = w_en;
        act.r_addr = r_addr;   act.en_A = en_A;         act.en_B = en_B;
        act.shift_op = shift_op; act.sel_A = sel_A;     act.sel_B = sel_B;
        act.alu = ALU_op;      act.en_C = en_C;         act.en_status = en_status;
    end

    // Behavioural model: an accepted instruction expands into its list of phases
    ovec_t q[$];
    ovec_t cur = '0;

    function automatic ovec_t idle_vec(input logic e);
        idle_vec = '0;
        idle_vec.err = e;
    endfunction

    task automatic expand(input logic [15:0] ins);
        ovec_t base, s;
        string mn;
        base = '0;
        base.busy = 1'b1;
        case (ins[15:11])
            5'b11010: mn = "MOVI";
            5'b11000: mn = "MOV";
            5'b10100: mn = "ADD";
            5'b10101: mn = "CMP";
            5'b10110: mn = "AND";
            5'b10111: mn = "MVN";
            default:  mn = "ILL";
        endcase
        q.push_back(base);
        if (mn == "MOVI") begin
            s = base; s.wb_sel = 1'b1; s.w_addr = ins[10:8]; s.w_en = 1'b1;
            s.dpin   = {{8{ins[7]}}, ins[7:0]};
            s.dpin_z = {8'h00, ins[7:0]};
            q.push_back(s);
        end else if (mn != "ILL") begin
            if (mn == "ADD" || mn == "AND" || mn == "CMP") begin
                s = base; s.r_addr = ins[10:8]; s.en_A = 1'b1; q.push_back(s);
            end
            s = base; s.r_addr = ins[2:0]; s.en_B = 1'b1; q.push_back(s);
            s = base; s.shift_op = ins[4:3];
            s.sel_A     = (mn == "MOV");
            s.alu       = (mn == "AND") ? 2'b10 : (mn == "MVN") ? 2'b11 :
                          (mn == "CMP") ? 2'b01 : 2'b00;
            s.en_C      = (mn != "CMP");
            s.en_status = (mn == "CMP");
            q.push_back(s);
            if (mn != "CMP") begin
                s = base; s.w_addr = ins[7:5]; s.w_en = 1'b1; q.push_back(s);
            end
        end
        s = base; s.done = 1'b1; s.err = (mn == "ILL");
        q.push_back(s);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cur = '0;
        end else if (cur.busy) begin
            if (q.size() > 0) cur = q.pop_front();
            else              cur = idle_vec(cur.err);
        end else if (start) begin
            expand(instr_in);
            cur = q.pop_front();
        end else begin
            cur = idle_vec(cur.err);
        end
    end

    always @(negedge clk) begin
        if (chk_en) check("cycle_outputs", act, cur);
    end

    // Register file, shifter and ALU driven by the controller outputs
    logic [15:0] rf [8] = '{default: 16'h0000};
    logic [15:0] ra = '0, rb = '0, rc = '0, alu_res, b_sh;
    logic        zf = 1'b1;

    always_comb begin
        case (shift_op)
            2'b01:   b_sh = rb << 1;
            2'b10:   b_sh = rb >> 1;
            2'b11:   b_sh = {rb[15], rb[15:1]};
            default: b_sh = rb;
        endcase
        case (ALU_op)
            2'b01:   alu_res = (sel_A ? 16'h0 : ra) - b_sh;
            2'b10:   alu_res = (sel_A ? 16'h0 : ra) & b_sh;
            2'b11:   alu_res = ~b_sh;
            default: alu_res = (sel_A ? 16'h0 : ra) + b_sh;
        endcase
    end

    always @(posedge clk) begin
        if (w_en)      rf[w_addr] <= wb_sel ? datapath_in : rc;
        if (en_A)      ra <= rf[r_addr];
        if (en_B)      rb <= rf[r_addr];
        if (en_C)      rc <= alu_res;
        if (en_status) zf <= (alu_res == 16'h0);
    end

    logic        saw_wen, saw_en;
    logic [15:0] wimm_dpin, wimm_dpin_z;

    task automatic run_instr(input logic [15:0] ins, input int exp_lat,
                             input logic exp_err, input bit hold);
        int cnt;
        @(negedge clk);
        start    = 1'b1;
        instr_in = ins;
        @(posedge clk);
        #1;
        cnt = 1;
        saw_wen = 1'b0;
        saw_en  = 1'b0;
        if (!hold) start = 1'b0;
        check("err_clear_on_accept", {63'd0, err}, 64'd0);
        for (int i = 0; i < 20; i++) begin
            if (w_en) saw_wen = 1'b1;
            if (w_en | en_A | en_B | en_C | en_status) saw_en = 1'b1;
            if (w_en && wb_sel) begin
                wimm_dpin   = datapath_in;
                wimm_dpin_z = z_datapath_in;
            end
            if (hold) instr_in = 16'hE000 ^ 16'(i * 16'h0123);
            if (done) break;
            @(posedge clk);
            #1;
            cnt++;
        end
        check("latency", 64'(cnt), 64'(exp_lat));
        check("err_with_done", {63'd0, err}, {63'd0, exp_err});
        @(posedge clk);
        #1;
        check("idle_after_done", {63'd0, busy}, 64'd0);
        start = 1'b0;
    endtask

    initial begin
        #3 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check("reset_outputs", act, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_outputs", act, 64'd0);

        run_instr(16'hD007, 3, 1'b0, 1'b0);
        check("movi7_dpin", 64'(wimm_dpin), 64'h0007);
        run_instr(16'hD1FE, 3, 1'b0, 1'b0);
        check("movi_sext_dpin", 64'(wimm_dpin), 64'hFFFE);
        check("movi_zext_dpin", 64'(wimm_dpin_z), 64'h00FE);
        run_instr(16'hA140, 6, 1'b0, 1'b0);
        check("add_r2", 64'(rf[2]), 64'h0005);
        run_instr(16'hA900, 5, 1'b0, 1'b0);
        check("cmp_no_wen", {63'd0, saw_wen}, 64'd0);
        check("cmp_z", {63'd0, zf}, 64'd0);
        run_instr(16'hB869, 5, 1'b0, 1'b0);
        check("mvn_r3", 64'(rf[3]), 64'h0003);
        run_instr(16'hE000, 2, 1'b1, 1'b0);
        check("illegal_no_enables", {63'd0, saw_en}, 64'd0);
        check("err_held_idle", {63'd0, err}, 64'd1);
        run_instr(16'hC0A1, 5, 1'b0, 1'b0);
        check("mov_r5", 64'(rf[5]), 64'hFFFE);
        run_instr(16'hB1E0, 6, 1'b0, 1'b1);
        check("and_hold_r7", 64'(rf[7]), 64'h0006);

        // Abort ADD R4,R1,R0 during EXEC
        @(negedge clk);
        start    = 1'b1;
        instr_in = 16'hA180;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("abort_in_exec", {63'd0, en_C}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", act, 64'd0);
        saw_en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (w_en | en_C | en_status) saw_en = 1'b1;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_enables", {63'd0, saw_en}, 64'd0);
        check("abort_r4_unwritten", 64'(rf[4]), 64'h0000);
        check("abort_idle", {63'd0, busy}, 64'd0);

        run_instr(16'hD007, 3, 1'b0, 1'b0);
        check("resume_movi_dpin", 64'(wimm_dpin), 64'h0007);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
